// File: rtl/var_table_pkg.sv
// Shared constants and types for the BCP variable table.
// Default geometry: 8 entries of 8-bit assignment masks.
package var_table_pkg;

    localparam int unsigned VAR_TABLE_ADDR_W  = 3;
    localparam int unsigned VAR_TABLE_VAR_NUM = 8;
    localparam int unsigned VAR_TABLE_DEPTH   = 1 << VAR_TABLE_ADDR_W;

    // One table entry at the default width
    typedef logic [VAR_TABLE_VAR_NUM-1:0] var_vec_t;

endpackage : var_table_pkg

// File: rtl/var_table_ram.sv
// Storage array for var_table: synchronous clear, synchronous write,
// asynchronous (combinational) read. The read data is registered by the top.
// Ports:
//   i_clk      clock, all state on rising edge
//   i_rst_n    synchronous active-low clear of every entry
//   i_wr_en    write strobe
//   i_addr     entry index for both read and write
//   i_wr_data  data written on i_wr_en
//   o_rd_data_c  combinational read of the addressed entry
module var_table_ram
    import var_table_pkg::*;
#(
    parameter int unsigned address_width = VAR_TABLE_ADDR_W,
    parameter int unsigned var_num       = VAR_TABLE_VAR_NUM
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wr_en,
    input  logic [address_width-1:0] i_addr,
    input  logic [var_num-1:0]       i_wr_data,
    output logic [var_num-1:0]       o_rd_data_c
);

    localparam int unsigned DEPTH = 1 << address_width;

    logic [var_num-1:0] r_mem [DEPTH];

    // Clear-all on reset, otherwise single-entry write
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end

    assign o_rd_data_c = r_mem[i_addr];

endmodule : var_table_ram

// File: rtl/var_table.sv
// Variable table for the BCP engine: single shared-address port that either
// reads or writes each cycle, with a registered read output.
// Optional build macro VAR_TABLE_WRITE_THROUGH_EN: when defined, a write also
// loads dout with din at the same edge; otherwise dout holds during writes.
// Ports:
//   clock    system clock
//   reset    synchronous active-low reset (clears table and dout)
//   en       access enable
//   r_w      1 = read, 0 = write
//   address  entry index
//   din      write data
//   dout     registered read data (1-cycle latency)
module var_table
    import var_table_pkg::*;
#(
    parameter int unsigned address_width = VAR_TABLE_ADDR_W,
    parameter int unsigned var_num       = VAR_TABLE_VAR_NUM
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     r_w,
    input  logic [address_width-1:0] address,
    input  logic [var_num-1:0]       din,
    output logic [var_num-1:0]       dout
);

    logic               w_rd;
    logic               w_wr;
    logic [var_num-1:0] w_rd_data;
    logic [var_num-1:0] r_dout;

    // Access decode
    assign w_rd = en &  r_w;
    assign w_wr = en & ~r_w;

    var_table_ram #(
        .address_width (address_width),
        .var_num       (var_num)
    ) u_ram (
        .i_clk       (clock),
        .i_rst_n     (reset),
        .i_wr_en     (w_wr),
        .i_addr      (address),
        .i_wr_data   (din),
        .o_rd_data_c (w_rd_data)
    );

    // Output register; reset wins over any access in the same cycle
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dout <= '0;
        end else if (w_rd) begin
            r_dout <= w_rd_data;
`ifdef VAR_TABLE_WRITE_THROUGH_EN
        end else if (w_wr) begin
            r_dout <= din;
`endif
        end
    end

    assign dout = r_dout;

endmodule : var_table

// File: tb/tb_var_table.sv
// Directed self-checking bench for var_table: default 3/8 instance plus a
// 4/16 instance for the parameter sweep.
module tb_var_table;

    logic        clk = 1'b0;
    logic        rst;
    logic        en,  rw;
    logic [2:0]  addr;
    logic [7:0]  din,  dout;
    logic        en2, rw2;
    logic [3:0]  addr2;
    logic [15:0] din2, dout2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    var_table #(.address_width(3), .var_num(8)) dut (
        .clock(clk), .reset(rst), .en(en), .r_w(rw),
        .address(addr), .din(din), .dout(dout)
    );

    var_table #(.address_width(4), .var_num(16)) dut2 (
        .clock(clk), .reset(rst), .en(en2), .r_w(rw2),
        .address(addr2), .din(din2), .dout(dout2)
    );

    // Advance one rising edge and settle past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        en = 1'b1; rw = 1'b0; addr = a; din = d;
        tick();
    endtask

    task automatic rd(input logic [2:0] a);
        en = 1'b1; rw = 1'b1; addr = a;
        tick();
    endtask

    task automatic wr2(input logic [3:0] a, input logic [15:0] d);
        en2 = 1'b1; rw2 = 1'b0; addr2 = a; din2 = d;
        tick();
    endtask

    task automatic rd2(input logic [3:0] a);
        en2 = 1'b1; rw2 = 1'b1; addr2 = a;
        tick();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; rw = 1'b1; addr = '0; din = '0;
        en2 = 1'b0; rw2 = 1'b1; addr2 = '0; din2 = '0;

        // Reset for two edges
        tick();
        tick();
        chk("reset_dout", 16'(dout), 16'h0000);
        chk("reset_dout2", dout2, 16'h0000);
        rst = 1'b1;

        // Every entry reads zero after reset
        for (int i = 0; i < 8; i++) begin
            rd(3'(i));
            chk($sformatf("reset_rd%0d", i), 16'(dout), 16'h0000);
        end

        // Writes; dout must hold the last read value (zero) throughout
        wr(3'd0, 8'hE0);
        wr(3'd1, 8'h90);
        wr(3'd2, 8'h48);
        wr(3'd3, 8'h18);
`ifndef VAR_TABLE_WRITE_THROUGH_EN
        chk("wr_hold", 16'(dout), 16'h0000);
`else
        chk("wr_through", 16'(dout), 16'h0018);
`endif

        rd(3'd0); chk("rd0", 16'(dout), 16'h00E0);
        rd(3'd1); chk("rd1", 16'(dout), 16'h0090);
        rd(3'd2); chk("rd2", 16'(dout), 16'h0048);
        rd(3'd3); chk("rd3", 16'(dout), 16'h0018);
        rd(3'd4); chk("rd4", 16'(dout), 16'h0000);

        // Enable gating: disabled write attempts change nothing
        en = 1'b0; rw = 1'b0; addr = 3'd1; din = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("idle_hold%0d", i), 16'(dout), 16'h0000);
        end
        rd(3'd1); chk("idle_rd1", 16'(dout), 16'h0090);

        // Back-to-back write then read of the same entry
        wr(3'd7, 8'hA5);
`ifndef VAR_TABLE_WRITE_THROUGH_EN
        chk("b2b_wr_hold", 16'(dout), 16'h0090);
`else
        chk("b2b_wr_through", 16'(dout), 16'h00A5);
`endif
        rd(3'd7); chk("b2b_rd7", 16'(dout), 16'h00A5);

        // Reset coincident with a write: access discarded, table cleared
        rst = 1'b0; en = 1'b1; rw = 1'b0; addr = 3'd2; din = 8'h3C;
        tick();
        chk("midrst_dout", 16'(dout), 16'h0000);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rd(3'(i));
            chk($sformatf("midrst_rd%0d", i), 16'(dout), 16'h0000);
        end
        rd(3'd2); chk("midrst_rd2_again", 16'(dout), 16'h0000);
        rd(3'd7); chk("midrst_rd7", 16'(dout), 16'h0000);
        en = 1'b0;

        // Parameter sweep instance: 16 entries of 16 bits
        wr2(4'd15, 16'hBEEF);
        wr2(4'd0,  16'h1234);
        rd2(4'd15); chk("p_rd15", dout2, 16'hBEEF);
        rd2(4'd0);  chk("p_rd0",  dout2, 16'h1234);
        rd2(4'd1);  chk("p_rd1",  dout2, 16'h0000);
        rd2(4'd7);  chk("p_rd7",  dout2, 16'h0000);
        rd2(4'd14); chk("p_rd14", dout2, 16'h0000);
        rd2(4'd15); chk("p_rd15_again", dout2, 16'hBEEF);
        en2 = 1'b0;
        tick();
        chk("p_idle_hold", dout2, 16'hBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_var_table

// File: doc/var_table.md
Name: var_table

Overview:
- Small synchronous variable table (register-file RAM) for the hardware BCP engine.
- Holds one var_num-bit bit-vector per entry, 2**address_width entries.
- Single shared address; one port for either read or write each cycle; registered read data.
- Used by BCP logic to store and fetch per-clause/per-variable assignment masks.

Parameters:
- address_width, 3, width of the address bus; depth = 2**address_width entries (default 8).
- var_num, 8, width in bits of each entry and of din/dout.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-low reset; sampled on rising clock edge.
- en  input  1  access enable; no read or write occurs when 0.
- r_w  input  1  access type: 1 = read, 0 = write.
- address  input  address_width  entry index.
- din  input  var_num  write data.
- dout  output  var_num  registered read data.

Behaviour:
- All logic is on rising edge of clock. No combinational path from inputs to dout.
- Reset (reset==0 at a rising edge): every entry cleared to 0, dout cleared to 0. Reset has priority over en/r_w. Reset mid-operation discards that cycle's access.
- Write (reset==1, en==1, r_w==0): mem[address] <= din at the edge. dout holds its previous value.
- Read (reset==1, en==1, r_w==1): dout <= mem[address] at the edge. Latency is 1 cycle: address presented before edge N gives data valid after edge N.
- Idle (en==0): memory and dout unchanged.
- Every address in 0..2**address_width-1 is valid. No wrap-around or out-of-range case exists because the address is exactly address_width bits.
- Write followed by read of the same address on the next cycle returns the newly written data.
- No handshake and no busy state: an access is accepted every cycle.
- X/Z on address during an enabled access is a usage error. Behaviour is unspecified; the bench must not rely on it.

Optional Feature:
- Macro VAR_TABLE_WRITE_THROUGH_EN.
- Defined: during a write cycle, dout <= din at the same edge (write-through), so written data appears on dout one cycle later.
- Undefined: dout holds during writes, as specified above.
- All other behaviour is identical in both builds.

Decomposition:
- Package var_table_pkg holds:
  - default constants VAR_TABLE_ADDR_W=3 and VAR_TABLE_VAR_NUM=8;
  - derived VAR_TABLE_DEPTH = 1<<VAR_TABLE_ADDR_W;
  - a typedef for the entry vector, var_vec_t [var_num-1:0].
- One sub-module is natural: var_table_ram, the storage array with synchronous clear and write.
- Top var_table owns the r_w/en decode, the dout register and the write-through option.

Test Plan:
- Reset: hold reset=0 for 2 edges, release, then read addr 0..7 -> dout=8'h00 for every address, each one cycle after the read.
- Writes then reads: write addr0=8'b1110_0000, addr1=8'b1001_0000, addr2=8'b0100_1000, addr3=8'b0001_1000; then read addr0..3 -> dout = E0, 90, 48, 18 respectively; read addr4 -> 8'h00.
- Enable gating: en=0, r_w=0, addr1, din=8'hFF for several cycles, then read addr1 -> 8'h90 unchanged; dout stays constant while en=0.
- Back-to-back: write addr7=8'hA5, next cycle read addr7 -> dout=8'hA5 after one edge; dout unchanged during the write cycle (macro undefined), or dout=8'hA5 after the write edge (VAR_TABLE_WRITE_THROUGH_EN).
- Reset mid-run: after the write sequence, assert reset=0 for one edge coincident with a write of 8'h3C to addr2 -> dout=0; subsequent reads of addr0..3 and addr2 all return 8'h00.
- Parameter sweep: address_width=4, var_num=16; write 16'hBEEF to addr15 and 16'h1234 to addr0 -> reads return the same values; other addresses return 0.
